// File: rtl/wfi_sleep_controller.sv
// WFI low-power sequencer: drains fetch/LSU traffic, gates the core clock and
// releases the core on any enabled pending interrupt or debug request.
module wfi_sleep_controller #(
  parameter int IRQW          = 32,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int WAKE_DELAY    = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            wfi_req,
  input  logic            debug,
  input  logic            single_step,
  input  logic [IRQW-1:0] reg_mie,
  input  logic [IRQW-1:0] reg_mip,
  input  logic            bus_err_int,
  input  logic            debug_int,
  input  logic            clint_int,
  input  logic            fetch_outstanding,
  input  logic            mem_outstanding,
  output logic            wfi,
  output logic            clk_gate_en,
  output logic            wake,
  output logic            drain_timeout,
  output logic [31:0]     sleep_cycles
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SLEEP, S_WAKE} state_t;

  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_TIMEOUT - 1);
  localparam logic [3:0]  WAKE_LOAD  = 4'(WAKE_DELAY - 1);

  state_t      r_state, w_next;
  logic [15:0] r_drain_cnt;
  logic [3:0]  r_wake_cnt;
  logic        r_wake, r_drain_to;
  logic [31:0] r_sleep_cnt;

  logic w_pending, w_blocked;
  logic w_wake_set, w_to_set, w_drain_clr, w_drain_inc;
  logic w_wake_load, w_wake_dec, w_sleep_inc;

  assign w_pending = (|(reg_mie & reg_mip)) | bus_err_int | debug_int | clint_int;
  assign w_blocked = debug | single_step;

  always_comb begin
    w_next      = r_state;
    w_wake_set  = 1'b0;
    w_to_set    = 1'b0;
    w_drain_clr = 1'b0;
    w_drain_inc = 1'b0;
    w_wake_load = 1'b0;
    w_wake_dec  = 1'b0;
    w_sleep_inc = 1'b0;
    case (r_state)
      S_RUN: begin
        if (wfi_req) begin
          // A WFI that cannot sleep retires as a NOP but still signals resume.
          if (w_blocked || w_pending) begin
            w_wake_set = 1'b1;
          end else begin
            w_next      = S_DRAIN;
            w_drain_clr = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (w_pending || w_blocked) begin
          w_next     = S_RUN;
          w_wake_set = 1'b1;
        end else if (!fetch_outstanding && !mem_outstanding) begin
          w_next = S_SLEEP;
        end else if (r_drain_cnt == DRAIN_LAST) begin
          w_next     = S_RUN;
          w_wake_set = 1'b1;
          w_to_set   = 1'b1;
        end else begin
          w_drain_inc = 1'b1;
        end
      end
      S_SLEEP: begin
        if (w_pending || debug) begin
          w_next      = S_WAKE;
          w_wake_load = 1'b1;
        end else begin
          w_sleep_inc = 1'b1;
        end
      end
      S_WAKE: begin
        // Committed to waking: a dropped interrupt here does not re-enter SLEEP.
        if (r_wake_cnt == 4'd0) begin
          w_next     = S_RUN;
          w_wake_set = 1'b1;
        end else begin
          w_wake_dec = 1'b1;
        end
      end
      default: w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_RUN;
      r_drain_cnt <= '0;
      r_wake_cnt  <= '0;
      r_wake      <= 1'b0;
      r_drain_to  <= 1'b0;
      r_sleep_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_wake  <= w_wake_set;
      if (w_to_set)         r_drain_to  <= 1'b1;
      if (w_drain_clr)      r_drain_cnt <= '0;
      else if (w_drain_inc) r_drain_cnt <= r_drain_cnt + 16'd1;
      if (w_wake_load)      r_wake_cnt  <= WAKE_LOAD;
      else if (w_wake_dec)  r_wake_cnt  <= r_wake_cnt - 4'd1;
      if (w_sleep_inc && (r_sleep_cnt != 32'hFFFF_FFFF))
        r_sleep_cnt <= r_sleep_cnt + 32'd1;
    end
  end

  assign wfi           = (r_state == S_SLEEP) || (r_state == S_WAKE);
  assign clk_gate_en   = (r_state == S_SLEEP);
  assign wake          = r_wake;
  assign drain_timeout = r_drain_to;
  assign sleep_cycles  = r_sleep_cnt;

endmodule

// File: tb/tb_wfi_sleep_controller.sv
// Directed bench for wfi_sleep_controller: sleep/wake timing, NOP WFI cases,
// drain wait/timeout and asynchronous reset while sleeping.
module tb_wfi_sleep_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wfi_req, debug, single_step;
  logic [31:0] reg_mie, reg_mip;
  logic        bus_err_int, debug_int, clint_int;
  logic        fetch_outstanding, mem_outstanding;
  logic        wfi, clk_gate_en, wake, drain_timeout;
  logic [31:0] sleep_cycles;

  int n_err = 0;
  int n_chk = 0;

  wfi_sleep_controller #(.IRQW(32), .DRAIN_TIMEOUT(64), .WAKE_DELAY(2)) dut (
    .clock(clock), .reset_n(reset_n), .wfi_req(wfi_req), .debug(debug),
    .single_step(single_step), .reg_mie(reg_mie), .reg_mip(reg_mip),
    .bus_err_int(bus_err_int), .debug_int(debug_int), .clint_int(clint_int),
    .fetch_outstanding(fetch_outstanding), .mem_outstanding(mem_outstanding),
    .wfi(wfi), .clk_gate_en(clk_gate_en), .wake(wake),
    .drain_timeout(drain_timeout), .sleep_cycles(sleep_cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs driven here belong to the cycle following this edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; wfi_req = 1'b0; debug = 1'b0; single_step = 1'b0;
    reg_mie = '0; reg_mip = '0; bus_err_int = 1'b0; debug_int = 1'b0;
    clint_int = 1'b0; fetch_outstanding = 1'b0; mem_outstanding = 1'b0;
    #12;
    chk("rst_wfi",   {31'd0, wfi},           32'd0);
    chk("rst_cge",   {31'd0, clk_gate_en},   32'd0);
    chk("rst_wake",  {31'd0, wake},          32'd0);
    chk("rst_dto",   {31'd0, drain_timeout}, 32'd0);
    chk("rst_sleep", sleep_cycles,           32'd0);
    reset_n = 1'b1;
    tick();

    // Basic: request in cycle 10, CLINT in cycle 30 (times relative to request).
    wfi_req = 1'b1;
    tick();                                   // edge 11: DRAIN
    wfi_req = 1'b0;
    chk("basic_drain_wfi", {31'd0, wfi}, 32'd0);
    tick();                                   // edge 12: SLEEP
    chk("basic_wfi_rise", {31'd0, wfi}, 32'd1);
    chk("basic_cge_rise", {31'd0, clk_gate_en}, 32'd1);
    for (int i = 13; i <= 30; i++) begin
      tick();
      chk($sformatf("basic_cge_%0d", i), {31'd0, clk_gate_en}, 32'd1);
    end
    clint_int = 1'b1;                         // cycle 30
    tick();                                   // edge 31: WAKE
    chk("basic_cge_fall", {31'd0, clk_gate_en}, 32'd0);
    chk("basic_wfi_31",   {31'd0, wfi}, 32'd1);
    chk("basic_count",    sleep_cycles, 32'd18);
    clint_int = 1'b0;                         // no return to SLEEP once waking
    tick();                                   // edge 32
    chk("basic_wfi_32",  {31'd0, wfi}, 32'd1);
    chk("basic_wake_32", {31'd0, wake}, 32'd0);
    tick();                                   // edge 33: RUN
    chk("basic_wfi_33",  {31'd0, wfi}, 32'd0);
    chk("basic_wake_33", {31'd0, wake}, 32'd1);
    tick();
    chk("basic_wake_end", {31'd0, wake}, 32'd0);
    chk("basic_count_hold", sleep_cycles, 32'd18);

    // Pending enabled interrupt at request time: NOP with resume pulse.
    reg_mie[7] = 1'b1; reg_mip[7] = 1'b1;
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
    chk("pend_wfi",  {31'd0, wfi}, 32'd0);
    chk("pend_wake", {31'd0, wake}, 32'd1);
    tick();
    chk("pend_wfi2",  {31'd0, wfi}, 32'd0);
    chk("pend_wake2", {31'd0, wake}, 32'd0);
    reg_mie = '0; reg_mip = '0;
    tick();

    // Drain wait: LSU busy cycles 10..15, SLEEP at edge 17.
    wfi_req = 1'b1; mem_outstanding = 1'b1;
    tick();                                   // edge 11: DRAIN
    wfi_req = 1'b0;
    for (int i = 12; i <= 16; i++) begin
      tick();
      chk($sformatf("dw_wfi_%0d", i), {31'd0, wfi}, 32'd0);
    end
    mem_outstanding = 1'b0;                   // cycle 16
    tick();                                   // edge 17
    chk("dw_sleep", {31'd0, clk_gate_en}, 32'd1);
    chk("dw_dto",   {31'd0, drain_timeout}, 32'd0);
    bus_err_int = 1'b1;
    tick(); tick(); tick();
    chk("dw_wake", {31'd0, wake}, 32'd1);
    bus_err_int = 1'b0;
    tick();

    // Drain timeout: fetch stuck, abort 64 edges after DRAIN entry.
    fetch_outstanding = 1'b1; wfi_req = 1'b1;
    tick();                                   // DRAIN entry edge e
    wfi_req = 1'b0;
    for (int i = 1; i < 64; i++) tick();
    chk("to_early_wake", {31'd0, wake}, 32'd0);
    chk("to_early_dto",  {31'd0, drain_timeout}, 32'd0);
    tick();                                   // e+64
    chk("to_wake", {31'd0, wake}, 32'd1);
    chk("to_dto",  {31'd0, drain_timeout}, 32'd1);
    chk("to_wfi",  {31'd0, wfi}, 32'd0);
    fetch_outstanding = 1'b0;
    tick();
    chk("to_wake_end", {31'd0, wake}, 32'd0);
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
    tick();
    chk("to_resleep", {31'd0, clk_gate_en}, 32'd1);
    // Debug halt request wakes from SLEEP.
    debug_int = 1'b1;
    tick();
    chk("dbgint_cge",  {31'd0, clk_gate_en}, 32'd0);
    chk("dbgint_wfi",  {31'd0, wfi}, 32'd1);
    debug_int = 1'b0;
    tick(); tick();
    chk("dbgint_wake", {31'd0, wake}, 32'd1);
    chk("to_dto_sticky", {31'd0, drain_timeout}, 32'd1);
    tick();

    // Blocked requests: single-step, then debug mode.
    single_step = 1'b1; wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0; single_step = 1'b0;
    chk("step_wfi",  {31'd0, wfi}, 32'd0);
    chk("step_wake", {31'd0, wake}, 32'd1);
    tick();
    chk("step_wake_end", {31'd0, wake}, 32'd0);
    debug = 1'b1; wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
    chk("dbg_wfi",  {31'd0, wfi}, 32'd0);
    chk("dbg_wake", {31'd0, wake}, 32'd1);
    debug = 1'b0;
    tick();
    chk("dbg_wfi2", {31'd0, wfi}, 32'd0);

    // Reset while sleeping with count at 40 (18 accumulated earlier).
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
    tick();                                   // SLEEP
    for (int i = 0; i < 22; i++) tick();
    chk("rs_count", sleep_cycles, 32'd40);
    chk("rs_cge",   {31'd0, clk_gate_en}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rs_wfi",   {31'd0, wfi}, 32'd0);
    chk("rs_cge0",  {31'd0, clk_gate_en}, 32'd0);
    chk("rs_wake",  {31'd0, wake}, 32'd0);
    chk("rs_dto",   {31'd0, drain_timeout}, 32'd0);
    chk("rs_count0", sleep_cycles, 32'd0);
    #2 reset_n = 1'b1;
    tick();
    chk("rs_run", {31'd0, wfi}, 32'd0);
    wfi_req = 1'b1;
    tick();
    wfi_req = 1'b0;
    tick();
    chk("rs_resleep", {31'd0, wfi}, 32'd1);
    tick();
    chk("rs_count1", sleep_cycles, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
